// File: rtl/entrada_sync_filtro.sv
// entrada_sync_filtro
// Multi-channel input conditioner. For each channel:
//   - optional per-channel inversion (INV_MASK)
//   - SYNC_STAGES-deep synchroniser
//   - symmetric debounce filter: the output changes only after FILT_CNT
//     consecutive synchronised samples disagree with it
//   - optional single-cycle RISE/FALL pulses on output transitions
// Optional feature macro: ENTRADA_SYNC_EDGE_EN
//   defined   -> RISE/FALL pulse registers are built
//   undefined -> RISE/FALL are tied to 0 and no edge flops exist
// Channels share nothing but the clock and reset.
module entrada_sync_filtro #(
  parameter int              N_CH        = 4,
  parameter int              SYNC_STAGES = 2,
  parameter int              FILT_CNT    = 8,
  parameter logic [N_CH-1:0] INV_MASK    = {N_CH{1'b0}}
) (
  input  logic            clkm,
  input  logic            reset,
  input  logic [N_CH-1:0] IN,
  output logic [N_CH-1:0] IN_SYNC,
  output logic [N_CH-1:0] RISE,
  output logic [N_CH-1:0] FALL
);

  // Counter wide enough for FILT_CNT; it only ever reaches FILT_CNT-1.
  localparam int            CW       = $clog2(FILT_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   st_q;
    logic [CW-1:0]          cnt;
    logic                   disagree;
    logic                   at_last;

    // Synchroniser chain; inversion is applied ahead of the first flop.
    always_ff @(posedge clkm or posedge reset) begin
      if (reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], IN[i] ^ INV_MASK[i]};
      end
    end

    assign s        = sync_q[SYNC_STAGES-1];
    assign disagree = (s != st_q);
    assign at_last  = (cnt == CNT_LAST);

    // Debounce: count consecutive disagreeing samples; any agreeing sample
    // restarts the count, and the FILT_CNT-th disagreeing sample commits.
    always_ff @(posedge clkm or posedge reset) begin
      if (reset) begin
        st_q <= 1'b0;
        cnt  <= '0;
      end else if (!disagree) begin
        cnt  <= '0;
      end else if (at_last) begin
        st_q <= s;
        cnt  <= '0;
      end else begin
        cnt  <= cnt + 1'b1;
      end
    end

    assign IN_SYNC[i] = st_q;

`ifdef ENTRADA_SYNC_EDGE_EN
    logic rise_q;
    logic fall_q;

    // Edge pulses are loaded on the same edge that commits the new state,
    // so they are high exactly during the first cycle of the new level.
    always_ff @(posedge clkm or posedge reset) begin
      if (reset) begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= disagree && at_last && s;
        fall_q <= disagree && at_last && !s;
      end
    end

    assign RISE[i] = rise_q;
    assign FALL[i] = fall_q;
`endif
  end

`ifndef ENTRADA_SYNC_EDGE_EN
  assign RISE = '0;
  assign FALL = '0;
`endif

endmodule

// File: tb/tb_entrada_sync_filtro.sv
// Bench for entrada_sync_filtro: directed stimulus, a queue-based reference
// model checked every cycle, and hand-computed literal expectations.
module tb_entrada_sync_filtro;

  localparam int         N    = 4;
  localparam int         SS   = 2;
  localparam int         F    = 8;
  localparam logic [3:0] MASK = 4'b1000;
`ifdef ENTRADA_SYNC_EDGE_EN
  localparam int         EDGE = 1;
`else
  localparam int         EDGE = 0;
`endif

  logic         clkm = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] in_raw = '0;
  logic [N-1:0] in_sync;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  int total = 0;
  int bad   = 0;
  int rise_cnt [N];
  int fall_cnt [N];

  always #5 clkm = ~clkm;

  entrada_sync_filtro #(
    .N_CH(N), .SYNC_STAGES(SS), .FILT_CNT(F), .INV_MASK(MASK)
  ) dut (
    .clkm(clkm), .reset(reset), .IN(in_raw),
    .IN_SYNC(in_sync), .RISE(rise), .FALL(fall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a delay line of raw samples gives the synchronised
  // value seen at each edge; the output flips once the last F samples since
  // the previous flip all disagree with it.
  int           dly  [N][$];
  int           hist [N][$];
  logic [N-1:0] exp_sync, exp_rise, exp_fall;

  always @(posedge clkm or posedge reset) begin
    if (reset) begin
      exp_sync = '0; exp_rise = '0; exp_fall = '0;
      for (int c = 0; c < N; c++) begin
        dly[c].delete();
        repeat (SS) dly[c].push_back(0);
        hist[c].delete();
      end
    end else begin
      exp_rise = '0; exp_fall = '0;
      for (int c = 0; c < N; c++) begin
        int s_now;
        bit all_opp;
        s_now = dly[c].pop_front();
        dly[c].push_back(int'(in_raw[c] ^ MASK[c]));
        hist[c].push_back(s_now);
        if (hist[c].size() > F) void'(hist[c].pop_front());
        all_opp = (hist[c].size() == F);
        foreach (hist[c][k]) if (hist[c][k] == int'(exp_sync[c])) all_opp = 1'b0;
        if (all_opp) begin
          exp_sync[c] = ~exp_sync[c];
          if (exp_sync[c]) exp_rise[c] = 1'b1;
          else             exp_fall[c] = 1'b1;
          hist[c].delete();
        end
      end
      if (EDGE == 0) begin
        exp_rise = '0; exp_fall = '0;
      end
    end
  end

  // Every-cycle comparison against the model, plus observed pulse counts.
  always @(negedge clkm) begin
    chk("cyc_in_sync", in_sync, exp_sync);
    chk("cyc_rise", rise, exp_rise);
    chk("cyc_fall", fall, exp_fall);
    for (int c = 0; c < N; c++) begin
      if (rise[c]) rise_cnt[c]++;
      if (fall[c]) fall_cnt[c]++;
    end
  end

  initial begin
    int r0, f0;
    for (int c = 0; c < N; c++) begin rise_cnt[c] = 0; fall_cnt[c] = 0; end

    // Reset state
    repeat (3) @(negedge clkm);
    chk("rst_in_sync", in_sync, 4'b0000);
    chk("rst_rise", rise, 4'b0000);
    chk("rst_fall", fall, 4'b0000);

    // Inverted channel 3 with IN[3]=0 qualifies high after edge 10
    reset = 1'b0;
    repeat (9) @(negedge clkm);
    chk("inv_pre", in_sync, 4'b0000);
    @(negedge clkm);
    chk("inv_sync", in_sync, 4'b1000);
    chk("inv_rise", rise, (EDGE != 0) ? 4'b1000 : 4'b0000);
    @(negedge clkm);
    chk("inv_rise_off", rise, 4'b0000);

    // Channel 0 rises after edge 10, others unaffected
    in_raw[0] = 1'b1;
    repeat (9) @(negedge clkm);
    chk("ch0_pre", in_sync, 4'b1000);
    @(negedge clkm);
    chk("ch0_sync", in_sync, 4'b1001);
    chk("ch0_rise", rise, (EDGE != 0) ? 4'b0001 : 4'b0000);

    // Channel 1 high for only 7 cycles: no change, no pulses
    repeat (5) @(negedge clkm);
    in_raw[1] = 1'b1;
    repeat (7) @(negedge clkm);
    in_raw[1] = 1'b0;
    repeat (20) @(negedge clkm);
    chk("ch1_short", in_sync, 4'b1001);
    chk("ch1_no_rise", rise_cnt[1], 0);
    chk("ch1_no_fall", fall_cnt[1], 0);

    // Channel 2 bounce: high 5, low 1, high 20, then low
    r0 = rise_cnt[2]; f0 = fall_cnt[2];
    in_raw[2] = 1'b1;
    repeat (5) @(negedge clkm);
    in_raw[2] = 1'b0;
    @(negedge clkm);
    in_raw[2] = 1'b1;
    repeat (9) @(negedge clkm);
    chk("ch2_pre", in_sync[2], 1'b0);
    @(negedge clkm);
    chk("ch2_sync", in_sync[2], 1'b1);
    repeat (10) @(negedge clkm);
    in_raw[2] = 1'b0;
    repeat (9) @(negedge clkm);
    chk("ch2_fall_pre", in_sync[2], 1'b1);
    @(negedge clkm);
    chk("ch2_fall", in_sync[2], 1'b0);
    chk("ch2_fall_pulse", fall, (EDGE != 0) ? 4'b0100 : 4'b0000);
    repeat (2) @(negedge clkm);
    chk("ch2_rise_count", rise_cnt[2] - r0, EDGE);
    chk("ch2_fall_count", fall_cnt[2] - f0, EDGE);

    // Channel 3 starts to fall, reset hits at count 5
    in_raw[3] = 1'b1;
    repeat (7) @(negedge clkm);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sync", in_sync, 4'b0000);
    chk("mid_rst_rise", rise, 4'b0000);
    chk("mid_rst_fall", fall, 4'b0000);
    repeat (2) @(negedge clkm);
    reset = 1'b0;

    // After release: channel 0 (held high) qualifies again, channel 3 stays low
    repeat (9) @(negedge clkm);
    chk("post_rst_pre", in_sync, 4'b0000);
    @(negedge clkm);
    chk("post_rst_sync", in_sync, 4'b0001);
    chk("post_rst_rise", rise, (EDGE != 0) ? 4'b0001 : 4'b0000);
    repeat (5) @(negedge clkm);
    chk("post_rst_ch3", in_sync, 4'b0001);

    // Channel 3 count starts from zero again
    in_raw[3] = 1'b0;
    repeat (9) @(negedge clkm);
    chk("ch3_restart_pre", in_sync[3], 1'b0);
    @(negedge clkm);
    chk("ch3_restart", in_sync[3], 1'b1);
    chk("ch3_restart_rise", rise, (EDGE != 0) ? 4'b1000 : 4'b0000);
    repeat (3) @(negedge clkm);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/entrada_sync_filtro.md
ENTRADA_SYNC_FILTRO -- requirements
Module: entrada_sync_filtro

Interface
REQ-001 Parameter N_CH, default 4, number of independent input channels (>=1).
REQ-002 Parameter SYNC_STAGES, default 2, synchroniser flop depth per channel (>=2).
REQ-003 Parameter FILT_CNT, default 8, consecutive stable samples required to change output (>=1).
REQ-004 Parameter INV_MASK, default {N_CH{1'b0}}, per-channel input inversion applied before synchroniser.
REQ-005 Port clkm, input, 1, sole clock; all flops rising-edge.
REQ-006 Port reset, input, 1, asynchronous active-high reset.
REQ-007 Port IN, input, N_CH, asynchronous raw inputs.
REQ-008 Port IN_SYNC, output, N_CH, synchronised, debounced level per channel.
REQ-009 Port RISE, output, N_CH, one-cycle pulse on IN_SYNC 0->1.
REQ-010 Port FALL, output, N_CH, one-cycle pulse on IN_SYNC 1->0.

Function
REQ-011 Each channel SHALL be fully independent; no shared state between channels.
REQ-012 Channel i SHALL sample IN[i]^INV_MASK[i] into a SYNC_STAGES-deep flop chain; last stage is s[i].
REQ-013 Each channel SHALL hold registered state st[i] and counter cnt[i], width $clog2(FILT_CNT+1).
REQ-014 Per edge: s[i]==st[i] -> cnt[i]<=0; s[i]!=st[i] and cnt[i]<FILT_CNT-1 -> cnt[i]+1; s[i]!=st[i] and cnt[i]==FILT_CNT-1 -> st[i]<=s[i], cnt[i]<=0.
REQ-015 Filter is symmetric: identical qualification for rising and falling transitions (unlike a high-only AND filter).
REQ-016 IN_SYNC[i] SHALL equal st[i] directly (registered, no combinational path from IN).
REQ-017 Latency: input stable from sampling edge 1 -> IN_SYNC changes after edge SYNC_STAGES+FILT_CNT.
REQ-018 Any s[i] excursion shorter than FILT_CNT cycles SHALL not change IN_SYNC[i]; a single opposite sample restarts the count.
REQ-019 FILT_CNT=1: st[i] follows s[i] with one extra register delay; cnt[i] never leaves 0.
REQ-020 Counter SHALL never exceed FILT_CNT-1; no wrap-around.
REQ-021 RISE[i]/FALL[i] SHALL be registered, asserted for exactly the first cycle IN_SYNC[i] holds its new value; never both high.
REQ-022 Minimum spacing between consecutive edge pulses on one channel is FILT_CNT cycles.

Reset
REQ-023 reset high SHALL asynchronously clear all synchroniser flops, st, cnt, IN_SYNC, RISE, FALL to 0.
REQ-024 Reset asserted mid-count SHALL discard the partial count; no edge pulse generated by reset itself.
REQ-025 After reset release with input (post-INV_MASK) high, channel SHALL qualify normally and emit RISE after REQ-017 latency.

Configuration
REQ-026 Macro ENTRADA_SYNC_EDGE_EN defined: RISE/FALL logic per REQ-021 compiled in.
REQ-027 Macro ENTRADA_SYNC_EDGE_EN undefined: RISE and FALL ports remain, tied constant 0; no edge flops synthesised; IN_SYNC behaviour unchanged.

Verification (defaults N_CH=4, SYNC_STAGES=2, FILT_CNT=8, macro defined unless noted)
REQ-028 IN[0] 0->1 before edge 1, held -> IN_SYNC[0]=1 after edge 10, RISE[0]=1 for that single cycle, channels 1-3 stay 0.
REQ-029 IN[1] high for 7 cycles then low -> IN_SYNC[1], RISE[1], FALL[1] remain 0 throughout.
REQ-030 IN[2] bounce high 5, low 1, high 20 cycles -> IN_SYNC[2] rises 10 edges after start of the 20-cycle high; exactly one RISE pulse; later low held 8+ cycles -> one FALL pulse.
REQ-031 INV_MASK=4'b1000, IN[3]=0 from reset release -> IN_SYNC[3]=1 after edge 10 with RISE[3]; reset pulsed at count 5 of a later transition -> all outputs 0 immediately, count restarts.
REQ-032 Macro undefined, repeat REQ-028 -> IN_SYNC[0] identical timing, RISE and FALL constant 0.
